// File: rtl/fetch_db_ref_loader_pkg.sv
// Shared definitions for the deblocking top-reference loader.
//   FETCH_EXT_W    : external read-data word width
//   FETCH_ROW_W    : reference buffer row width (four external words)
//   FETCH_REF_ROWS : rows in the reference buffer
//   fetch_state_e  : loader FSM state encoding
package enc_defines;

    localparam int unsigned FETCH_EXT_W    = 32;
    localparam int unsigned FETCH_ROW_W    = 128;
    localparam int unsigned FETCH_REF_ROWS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_word_packer.sv
// 4:1 word packer: collects four external words into one buffer row.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : drop any partial row and restart at word 0
//   push_i   : a word transfers this cycle
//   word_i   : the transferring word
//   last_o   : this push completes a row (combinational)
//   row_o    : last completed row, registered, held until the next one completes
module fetch_word_packer
    import enc_defines::*;
#(
    parameter int unsigned EXT_W = FETCH_EXT_W,
    parameter int unsigned ROW_W = FETCH_ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [EXT_W-1:0] word_i,
    output logic             last_o,
    output logic [ROW_W-1:0] row_o
);

    logic [1:0]           wc_q;
    // Holds words 0..2; the outgoing row lives separately in row_o so the
    // next row can start filling while the previous one is being written.
    logic [3*EXT_W-1:0]   pack_q;

    assign last_o = push_i && (wc_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q   <= 2'd0;
            pack_q <= '0;
            row_o  <= '0;
        end else if (clr_i) begin
            wc_q <= 2'd0;
        end else if (push_i) begin
            wc_q <= wc_q + 2'd1;
            // First word lands in the MSBs (left-most pixels).
            unique case (wc_q)
                2'd0: pack_q[3*EXT_W-1 -: EXT_W] <= word_i;
                2'd1: pack_q[2*EXT_W-1 -: EXT_W] <= word_i;
                2'd2: pack_q[EXT_W-1   -: EXT_W] <= word_i;
                2'd3: row_o <= {pack_q, word_i};
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_db_ref_loader.sv
// Fills the 16x128 deblocking top-reference buffer from the external read
// channel, packing four 32-bit words per row.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : load request (IDLE only), with num_rows_i (1..16), base_row_i
//   abort_i           : cancel the load in progress
//   ext_valid_i/ext_data_i/ext_ready_o : external word handshake
//   we_o/waddr_o/wdata_o : buffer write port
//   busy_o            : load in progress
//   rows_done_o       : rows written in the current load
//   done_o            : one-cycle completion pulse
module fetch_db_ref_loader
    import enc_defines::*;
#(
    parameter int unsigned EXT_W  = FETCH_EXT_W,
    parameter int unsigned ROW_W  = FETCH_ROW_W,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_rows_i,
    input  logic [ADDR_W-1:0] base_row_i,
    input  logic              abort_i,
    input  logic              ext_valid_i,
    input  logic [EXT_W-1:0]  ext_data_i,
    output logic              ext_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [ROW_W-1:0]  wdata_o,
    output logic              busy_o,
    output logic [ADDR_W:0]   rows_done_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ROW_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    fetch_state_e      state_q;
    logic [ADDR_W:0]   num_rows_q;
    logic [ADDR_W-1:0] base_q;

    logic xfer;
    logic start_ok;
    logic pack_clr;
    logic row_last;

    // Depends only on state and abort_i, never on ext_valid_i.
    assign ext_ready_o = (state_q == LOAD) && !abort_i;
    assign xfer        = ext_valid_i && ext_ready_o;
    assign start_ok    = start_i && (num_rows_i != '0) && (num_rows_i <= MAX_ROWS);
    assign pack_clr    = ((state_q == IDLE) && start_ok) || ((state_q == LOAD) && abort_i);

    fetch_word_packer #(
        .EXT_W (EXT_W),
        .ROW_W (ROW_W)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (pack_clr),
        .push_i (xfer),
        .word_i (ext_data_i),
        .last_o (row_last),
        .row_o  (wdata_o)
    );

    // rows_done_o doubles as the row counter: it is the offset of the next row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_rows_q  <= '0;
            base_q      <= '0;
            we_o        <= 1'b0;
            waddr_o     <= '0;
            busy_o      <= 1'b0;
            rows_done_o <= '0;
            done_o      <= 1'b0;
        end else begin
            we_o   <= 1'b0;
            done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q     <= LOAD;
                        busy_o      <= 1'b1;
                        num_rows_q  <= num_rows_i;
                        base_q      <= base_row_i;
                        rows_done_o <= '0;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else if (row_last) begin
                        we_o        <= 1'b1;
                        waddr_o     <= base_q + rows_done_o[ADDR_W-1:0];
                        rows_done_o <= rows_done_o + ROW_ONE;
                        if (rows_done_o + ROW_ONE == num_rows_q) begin
                            state_q <= DONE;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_o  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_db_ref_loader.sv
module tb_fetch_db_ref_loader;

    typedef struct packed {
        logic [3:0]   addr;
        logic [127:0] data;
        logic [4:0]   rd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [4:0]   num_rows_i;
    logic [3:0]   base_row_i;
    logic         abort_i;
    logic         ext_valid_i;
    logic [31:0]  ext_data_i;
    logic         ext_ready_o;
    logic         we_o;
    logic [3:0]   waddr_o;
    logic [127:0] wdata_o;
    logic         busy_o;
    logic [4:0]   rows_done_o;
    logic         done_o;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_db_ref_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .base_row_i  (base_row_i),
        .abort_i     (abort_i),
        .ext_valid_i (ext_valid_i),
        .ext_data_i  (ext_data_i),
        .ext_ready_o (ext_ready_o),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o),
        .rows_done_o (rows_done_o),
        .done_o      (done_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected row.
    always @(negedge clk) begin
        if (!rst && we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%0h required none",
                         waddr_o, wdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("waddr", 128'(waddr_o), 128'(e.addr));
                check("wdata", wdata_o, e.data);
                check("rows_done_at_write", 128'(rows_done_o), 128'(e.rd));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_o) done_cnt++;
    end

    function automatic logic [31:0] mk_word(input logic [7:0] tag, input logic [7:0] r,
                                            input logic [7:0] k);
        return {tag, r, k, 8'h5A};
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_word(input logic [31:0] d);
        logic acc;
        int   n;
        ext_valid_i = 1'b1;
        ext_data_i  = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ext_ready_o;
            @(posedge clk);
            n++;
        end
        #1;
        ext_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted word=%0h", d);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [4:0] n, input logic [3:0] base);
        start_i    = 1'b1;
        num_rows_i = n;
        base_row_i = base;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic load_row(input logic [3:0] addr, input logic [4:0] rd, input logic [7:0] tag,
                            input logic [7:0] r, input int maxgap);
        exp_t e;
        e.addr = addr;
        e.data = {mk_word(tag, r, 8'd0), mk_word(tag, r, 8'd1),
                  mk_word(tag, r, 8'd2), mk_word(tag, r, 8'd3)};
        e.rd   = rd;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            if (maxgap > 0) idle_cycles($urandom_range(0, maxgap));
            send_word(mk_word(tag, r, 8'(k)));
        end
    endtask

    initial begin
        int   d0;
        exp_t e;
        rst = 1'b1;
        start_i = 1'b0;
        num_rows_i = '0;
        base_row_i = '0;
        abort_i = 1'b0;
        ext_valid_i = 1'b0;
        ext_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 128'(ext_ready_o), 128'(0));
        check("reset_we", 128'(we_o), 128'(0));
        check("reset_busy_done", 128'({busy_o, done_o}), 128'(0));
        check("reset_waddr_rows", 128'({waddr_o, rows_done_o}), 128'(0));
        check("reset_wdata", wdata_o, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);

        // Basic single row
        start_load(5'd1, 4'd0);
        @(negedge clk);
        check("busy_after_start", 128'(busy_o), 128'(1));
        check("ready_after_start", 128'(ext_ready_o), 128'(1));
        @(posedge clk);
        #1;
        e.addr = 4'd0;
        e.data = 128'h000102030405060708090A0B0C0D0E0F;
        e.rd   = 5'd1;
        exp_q.push_back(e);
        send_word(32'h00010203);
        send_word(32'h04050607);
        send_word(32'h08090A0B);
        send_word(32'h0C0D0E0F);
        @(negedge clk);
        check("basic_we_t1", 128'(we_o), 128'(1));
        check("basic_ready_drop", 128'(ext_ready_o), 128'(0));
        check("basic_done_t1", 128'(done_o), 128'(0));
        @(negedge clk);
        check("basic_done_t2", 128'(done_o), 128'(1));
        @(negedge clk);
        check("basic_done_t3", 128'(done_o), 128'(0));
        check("basic_busy_end", 128'(busy_o), 128'(0));
        @(posedge clk);
        #1;

        // Full 16-row load, continuous
        d0 = done_cnt;
        start_load(5'd16, 4'd0);
        for (int r = 0; r < 16; r++) load_row(4'(r), 5'(r + 1), 8'hF1, 8'(r), 0);
        @(negedge clk);
        check("full_rows_done", 128'(rows_done_o), 128'(16));
        check("full_ready_drop", 128'(ext_ready_o), 128'(0));
        @(posedge clk);
        #1;
        idle_cycles(3);
        check("full_done_count", 128'(done_cnt - d0), 128'(1));

        // Wrap with random stalls
        d0 = done_cnt;
        start_load(5'd4, 4'd14);
        for (int r = 0; r < 4; r++) load_row(4'(14 + r), 5'(r + 1), 8'hB2, 8'(r), 2);
        idle_cycles(4);
        check("wrap_rows_done", 128'(rows_done_o), 128'(4));
        check("wrap_done_count", 128'(done_cnt - d0), 128'(1));

        // Abort after 6 words of a 3-row load; abort beats a valid word
        d0 = done_cnt;
        start_load(5'd3, 4'd5);
        load_row(4'd5, 5'd1, 8'hA3, 8'd0, 0);
        send_word(mk_word(8'hA3, 8'd1, 8'd0));
        send_word(mk_word(8'hA3, 8'd1, 8'd1));
        abort_i = 1'b1;
        ext_valid_i = 1'b1;
        ext_data_i = 32'hDEADBEEF;
        @(negedge clk);
        check("abort_ready", 128'(ext_ready_o), 128'(0));
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        ext_valid_i = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy_o), 128'(0));
        check("abort_rows_done", 128'(rows_done_o), 128'(1));
        @(posedge clk);
        #1;
        idle_cycles(3);
        check("abort_no_done", 128'(done_cnt - d0), 128'(0));
        start_load(5'd1, 4'd3);
        load_row(4'd3, 5'd1, 8'hA4, 8'd0, 0);
        idle_cycles(3);
        check("after_abort_done", 128'(done_cnt - d0), 128'(1));

        // Illegal row counts are ignored
        start_load(5'd0, 4'd0);
        @(negedge clk);
        check("zero_rows_idle", 128'({busy_o, ext_ready_o}), 128'(0));
        @(posedge clk);
        #1;
        start_load(5'd17, 4'd0);
        @(negedge clk);
        check("17_rows_idle", 128'({busy_o, ext_ready_o}), 128'(0));
        @(posedge clk);
        #1;

        // start_i during LOAD is ignored
        d0 = done_cnt;
        start_load(5'd2, 4'd8);
        load_row(4'd8, 5'd1, 8'hC5, 8'd0, 0);
        start_load(5'd1, 4'd0);
        check("restart_ignored_busy", 128'(busy_o), 128'(1));
        load_row(4'd9, 5'd2, 8'hC5, 8'd1, 0);
        idle_cycles(3);
        check("restart_done_count", 128'(done_cnt - d0), 128'(1));

        // Reset mid-load discards the partial row
        start_load(5'd2, 4'd2);
        send_word(32'h11111111);
        send_word(32'h22222222);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 128'(ext_ready_o), 128'(0));
        check("rst_busy_we_done", 128'({busy_o, we_o, done_o}), 128'(0));
        check("rst_waddr_rows", 128'({waddr_o, rows_done_o}), 128'(0));
        check("rst_wdata", wdata_o, 128'(0));
        rst = 1'b0;
        idle_cycles(1);
        d0 = done_cnt;
        start_load(5'd1, 4'd0);
        load_row(4'd0, 5'd1, 8'hE6, 8'd0, 0);
        idle_cycles(3);
        check("post_rst_done", 128'(done_cnt - d0), 128'(1));

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
